// File: rtl/popcount_stream_pkg.sv
// Shared definitions for the popcount_stream block.
//   state_e     : FSM encoding (IDLE, COUNT, DONE), also driven onto the
//                 state_dbg port of the top level.
//   count_width : bits needed to hold a popcount of a word of the given
//                 width, including the all-ones case ($clog2(width)+1).
package popcount_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int count_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational popcount of one chunk of the input word.
// Ports:
//   chunk : CHUNK_WIDTH-bit slice to count
//   count : number of 1 bits in chunk, count_width(CHUNK_WIDTH) bits wide
module popcount_chunk
    import popcount_stream_pkg::*;
#(
    parameter int CHUNK_WIDTH = 4
) (
    input  logic [CHUNK_WIDTH-1:0]              chunk,
    output logic [count_width(CHUNK_WIDTH)-1:0] count
);

    localparam int CCW = count_width(CHUNK_WIDTH);

    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            count = count + CCW'(chunk[i]);
        end
    end

endmodule

// File: rtl/popcount_stream.sv
// Streaming popcount: accepts one DATA_WIDTH word, counts its 1 bits
// CHUNK_WIDTH bits per cycle, then presents the result until consumed.
// An optional saturating accumulator sums every consumed result.
//
// Configuration macro: POPCOUNT_STREAM_ACC_EN
//   defined   -> accumulator (acc, acc_sat, acc_clr) is built
//   undefined -> acc and acc_sat tied to 0, acc_clr ignored
//
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready are both high. din_ready depends only on the FSM state (high in
// IDLE), dout_valid is a register; neither depends combinationally on the
// partner's valid/ready. dout is held stable while dout_valid is high.
//
// Ports:
//   clk, resetn            : clock, asynchronous active-low reset
//   din, din_valid/ready   : input word stream
//   dout, dout_valid/ready : popcount result stream
//   acc_clr                : synchronous clear of the running total
//   acc, acc_sat           : saturating running total and sticky flag
//   state_dbg              : current FSM state (state_e encoding)
//
// DATA_WIDTH must be an integer multiple of CHUNK_WIDTH.
module popcount_stream
    import popcount_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int CHUNK_WIDTH = 4,
    parameter int ACC_WIDTH   = 16
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic [DATA_WIDTH-1:0]              din,
    input  logic                               din_valid,
    output logic                               din_ready,
    output logic [count_width(DATA_WIDTH)-1:0] dout,
    output logic                               dout_valid,
    input  logic                               dout_ready,
    input  logic                               acc_clr,
    output logic [ACC_WIDTH-1:0]               acc,
    output logic                               acc_sat,
    output logic [1:0]                         state_dbg
);

    localparam int CW     = count_width(DATA_WIDTH);
    localparam int CCW    = count_width(CHUNK_WIDTH);
    localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    state_e                  state_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [CW-1:0]           part_q;
    logic [CW-1:0]           part_d;
    logic [IDXW-1:0]         idx_q;
    logic [CW-1:0]           dout_q;
    logic                    dout_valid_q;
    logic [CCW-1:0]          chunk_cnt;
    logic                    out_hs;

    popcount_chunk #(
        .CHUNK_WIDTH (CHUNK_WIDTH)
    ) u_chunk (
        .chunk (shift_q[CHUNK_WIDTH-1:0]),
        .count (chunk_cnt)
    );

    assign part_d     = part_q + CW'(chunk_cnt);
    assign din_ready  = (state_q == IDLE);
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign out_hs     = dout_valid_q & dout_ready;
    assign state_dbg  = state_q;

    // Only IDLE accepts din, so din changes in COUNT/DONE are ignored.
    // The last chunk is folded straight into dout_q so the result is
    // valid NCHUNK edges after the accepting edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            part_q       <= '0;
            idx_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (din_valid) begin
                        shift_q <= din;
                        part_q  <= '0;
                        idx_q   <= '0;
                        state_q <= COUNT;
                    end
                end
                COUNT: begin
                    shift_q <= shift_q >> CHUNK_WIDTH;
                    part_q  <= part_d;
                    idx_q   <= idx_q + IDXW'(1);
                    if (idx_q == LAST_IDX) begin
                        dout_q       <= part_d;
                        dout_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    // Returning to IDLE here means din_ready is low in the
                    // consuming cycle and rises one edge later.
                    if (dout_ready) begin
                        dout_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef POPCOUNT_STREAM_ACC_EN
    // One extra bit over the wider operand so the add cannot wrap before
    // the clamp compare.
    localparam int SW = ((ACC_WIDTH > CW) ? ACC_WIDTH : CW) + 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

    logic [ACC_WIDTH-1:0] acc_q;
    logic                 acc_sat_q;
    logic [SW-1:0]        sum_d;

    assign sum_d   = SW'(acc_q) + SW'(dout_q);
    assign acc     = acc_q;
    assign acc_sat = acc_sat_q;

    // acc_clr has priority: a result consumed in the clearing cycle is
    // dropped rather than added.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
        end else if (acc_clr) begin
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
        end else if (out_hs) begin
            if (sum_d > SW'(ACC_MAX)) begin
                acc_q     <= ACC_MAX;
                acc_sat_q <= 1'b1;
            end else begin
                acc_q <= sum_d[ACC_WIDTH-1:0];
                if (sum_d == SW'(ACC_MAX)) begin
                    acc_sat_q <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_acc_inputs;

    assign unused_acc_inputs = acc_clr ^ out_hs;
    assign acc               = '0;
    assign acc_sat           = 1'b0;
`endif

endmodule

// File: tb/tb_popcount_stream.sv
module tb_popcount_stream;

  localparam int DW = 16;
  localparam int CHW = 4;
  localparam int AW = 6;
  localparam int OW = 5;
  localparam int NCHUNK = DW / CHW;

  logic          clk;
  logic          resetn;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [OW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          acc_clr;
  logic [AW-1:0] acc;
  logic          acc_sat;
  logic [1:0]    state_dbg;

  popcount_stream #(
    .DATA_WIDTH  (DW),
    .CHUNK_WIDTH (CHW),
    .ACC_WIDTH   (AW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .acc_clr    (acc_clr),
    .acc        (acc),
    .acc_sat    (acc_sat),
    .state_dbg  (state_dbg)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int            tests = 0;
  int            fails = 0;
  logic [AW-1:0] exp_acc = '0;
  logic          exp_sat = 1'b0;

  typedef struct {
    logic [DW-1:0] din;
    logic [OW-1:0] exp_dout;
    int            stall;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // expected accumulator update on a consumed result
  task automatic model_consume(input logic [OW-1:0] r, input logic clr);
    int s;
`ifdef POPCOUNT_STREAM_ACC_EN
    if (clr) begin
      exp_acc = '0;
      exp_sat = 1'b0;
    end else begin
      s = int'(exp_acc) + int'(r);
      if (s > 63) begin
        exp_acc = 6'd63;
        exp_sat = 1'b1;
      end else begin
        exp_acc = AW'(s);
        if (s == 63) exp_sat = 1'b1;
      end
    end
`else
    s = int'(r) + int'(clr);
    exp_acc = '0;
    exp_sat = 1'b0;
`endif
  endtask

  // driver: send one word, check latency/result, optionally stall, consume
  task automatic run_word(input logic [DW-1:0] w, input logic [OW-1:0] exp,
                          input logic clr, input int stall);
    int k;
    k = 0;
    while (!din_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("din_ready_idle", din_ready, 1);
    din = w;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    check("din_ready_after_accept", din_ready, 0);
    k = 0;
    while (!dout_valid && k < 20) begin
      din = DW'($urandom);
      @(posedge clk); #1;
      k++;
    end
    check("latency", k, NCHUNK);
    check("dout", dout, exp);
    for (int i = 0; i < stall; i++) begin
      din = DW'($urandom);
      din_valid = 1'b1;
      @(posedge clk); #1;
      check("stall_dout", dout, exp);
      check("stall_dout_valid", dout_valid, 1);
      check("stall_din_ready", din_ready, 0);
      check("stall_acc", acc, exp_acc);
    end
    din_valid = 1'b0;
    acc_clr = clr;
    dout_ready = 1'b1;
    check("din_ready_consume_cycle", din_ready, 0);
    @(posedge clk); #1;
    dout_ready = 1'b0;
    acc_clr = 1'b0;
    model_consume(exp, clr);
    check("dout_valid_after_consume", dout_valid, 0);
    check("din_ready_after_consume", din_ready, 1);
    check("acc", acc, exp_acc);
    check("acc_sat", acc_sat, exp_sat);
  endtask

  initial begin
    vecs[0] = '{din: 16'hFFFF, exp_dout: 5'd16, stall: 0};
    vecs[1] = '{din: 16'h0000, exp_dout: 5'd0,  stall: 0};
    vecs[2] = '{din: 16'h8001, exp_dout: 5'd2,  stall: 0};
    vecs[3] = '{din: 16'h00F0, exp_dout: 5'd4,  stall: 1};
    vecs[4] = '{din: 16'hA5A5, exp_dout: 5'd8,  stall: 0};
    vecs[5] = '{din: 16'h1234, exp_dout: 5'd5,  stall: 2};
    vecs[6] = '{din: 16'h7FFF, exp_dout: 5'd15, stall: 0};
    vecs[7] = '{din: 16'h0001, exp_dout: 5'd1,  stall: 0};

    resetn = 1'b0;
    din = '0;
    din_valid = 1'b0;
    dout_ready = 1'b0;
    acc_clr = 1'b0;
    #12;
    check("reset_dout", dout, 0);
    check("reset_dout_valid", dout_valid, 0);
    check("reset_din_ready", din_ready, 1);
    check("reset_acc", acc, 0);
    check("reset_acc_sat", acc_sat, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    check("din_ready_after_release", din_ready, 1);

    // table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run_word(vecs[i].din, vecs[i].exp_dout, 1'b0, vecs[i].stall);
    end

    // acc_clr while idle: clears total, FSM untouched
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    model_consume('0, 1'b1);
    check("idle_clr_acc", acc, exp_acc);
    check("idle_clr_din_ready", din_ready, 1);
    check("idle_clr_dout_valid", dout_valid, 0);

    // long stall in DONE
    run_word(16'h0F0F, 5'd8, 1'b0, 10);

    // saturation: clear, then four all-ones words, then clear on handshake
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    model_consume('0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      run_word(16'hFFFF, 5'd16, 1'b0, 0);
    end
`ifdef POPCOUNT_STREAM_ACC_EN
    check("sat_acc_63", acc, 63);
    check("sat_flag", acc_sat, 1);
`endif
    run_word(16'hFFFF, 5'd16, 1'b1, 0);

    // reset during the second COUNT cycle
    din = 16'hFFFF;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    exp_acc = '0;
    exp_sat = 1'b0;
    check("midreset_dout", dout, 0);
    check("midreset_dout_valid", dout_valid, 0);
    check("midreset_din_ready", din_ready, 1);
    check("midreset_acc", acc, 0);
    check("midreset_acc_sat", acc_sat, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("midreset_ready_after_release", din_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("midreset_no_result", dout_valid, 0);
    end
    run_word(16'h00F0, 5'd4, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/popcount_stream.md
POPCOUNT_STREAM -- requirements
Module: popcount_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, input word width in bits.
REQ-002 SHALL have parameter CHUNK_WIDTH, default 4, bits counted per cycle; DATA_WIDTH SHALL be an integer multiple of CHUNK_WIDTH.
REQ-003 SHALL have parameter ACC_WIDTH, default 16, running-total accumulator width.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port din  input  DATA_WIDTH  word to be counted.
REQ-007 SHALL have port din_valid  input  1  din holds a valid word.
REQ-008 SHALL have port din_ready  output  1  block can accept a word this cycle.
REQ-009 SHALL have port dout  output  $clog2(DATA_WIDTH)+1  number of 1 bits in the accepted word.
REQ-010 SHALL have port dout_valid  output  1  dout holds a completed result.
REQ-011 SHALL have port dout_ready  input  1  consumer accepts dout this cycle.
REQ-012 SHALL have port acc_clr  input  1  synchronous clear of the running total.
REQ-013 SHALL have port acc  output  ACC_WIDTH  saturating sum of all consumed results.
REQ-014 SHALL have port acc_sat  output  1  sticky flag, acc has saturated.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, COUNT, DONE.
REQ-016 SHALL assert din_ready only in IDLE; input handshake = din_valid & din_ready.
REQ-017 On input handshake: latch din into a shift register, clear the partial count, go to COUNT.
REQ-018 In COUNT: each cycle add the popcount of the lowest CHUNK_WIDTH bits and shift right by CHUNK_WIDTH; after NCHUNK = DATA_WIDTH/CHUNK_WIDTH cycles go to DONE.
REQ-019 Latency: dout_valid SHALL rise exactly NCHUNK cycles after the input-handshake edge.
REQ-020 In DONE: dout_valid = 1, dout held stable; on dout_valid & dout_ready return to IDLE.
REQ-021 No new word SHALL be accepted in the cycle the result is consumed (minimum initiation interval NCHUNK+2 cycles).
REQ-022 dout SHALL never overflow: width $clog2(DATA_WIDTH)+1 holds the value DATA_WIDTH.
REQ-023 din changes while not in IDLE SHALL have no effect on the result.
REQ-024 On output handshake: acc <= min(acc + dout, 2^ACC_WIDTH-1); acc_sat set when the clamp applies or acc reaches all-ones.
REQ-025 acc_clr SHALL zero acc and acc_sat next edge; acc_clr in the same cycle as an output handshake wins, and that result is not added.
REQ-026 acc_clr SHALL not affect the FSM, dout or dout_valid.

Reset
REQ-027 resetn low SHALL immediately force state IDLE, dout = 0, dout_valid = 0, acc = 0, acc_sat = 0, and clear the shift register and partial count.
REQ-028 Reset asserted mid-COUNT or in DONE SHALL discard the word in flight; din_ready = 1 on the first edge after release.

Configuration
REQ-029 Macro POPCOUNT_STREAM_ACC_EN defined: accumulator per REQ-024..026 built.
REQ-030 Macro undefined: no accumulator registers; acc tied to 0, acc_sat tied to 0, acc_clr ignored; all other behaviour identical.

Structure
REQ-031 Package popcount_stream_pkg SHALL hold the FSM state enum (IDLE, COUNT, DONE) and a function computing the count width, $clog2(DATA_WIDTH)+1.
REQ-032 Sub-module popcount_chunk (combinational, CHUNK_WIDTH in, count out) SHALL compute the per-cycle chunk count.

Verification (DATA_WIDTH=16, CHUNK_WIDTH=4, ACC_WIDTH=6, macro defined)
REQ-033 din=16'hFFFF accepted, dout_ready=1 -> dout=16, dout_valid high exactly 4 cycles after the handshake edge, acc=16.
REQ-034 din=16'h0000 then 16'h8001 -> dout=0 then 2; din_ready low from acceptance until the cycle after consumption.
REQ-035 dout_ready held low 10 cycles in DONE -> dout and dout_valid stable, din_ready=0 throughout, acc unchanged until the handshake.
REQ-036 Four consecutive 16'hFFFF results -> acc=63 (clamped from 64), acc_sat=1; acc_clr with the next handshake -> acc=0, acc_sat=0.
REQ-037 resetn pulsed low during the 2nd COUNT cycle -> outputs zero immediately, no result produced; next word 16'h00F0 -> dout=4.
REQ-038 Macro undefined, REQ-033 stimulus -> dout=16, acc=0, acc_sat=0.
